multichannel_gated_counter: RTL and testbench

Parametrised successor to the fixed 4-channel pulse counter. Counts rising edges on NUM_CH asynchronous inputs over a programmable gate window measured in milliseconds. Counting is synchronous to clk; the block supports single-shot and continuous (back-to-back window) modes and flags saturation per channel. It sits on the 8-bit slow-control register bus and also exports snapshot counts in parallel.

---
 rtl/multichannel_gated_counter.sv | 202 ++++++++++++++++++++
 tb/tb_multichannel_gated_counter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_gated_counter.sv
// rtl/multichannel_gated_counter.sv - gated multi-channel rising-edge counter with slow-control registers
// Counts synchronised input edges over a programmable millisecond window, single-shot or continuous.
module multichannel_gated_counter #(
    parameter int         NUM_CH    = 4,
    parameter int         CNT_WIDTH = 32,
    parameter int         CLK_FREQ  = 200000000,
    parameter logic [7:0] BASE_ADDR = 8'h26
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  addr,
    input  logic [7:0]                  data_in,
    input  logic                        we,
    output logic [7:0]                  data_out,
    input  logic                        start,
    output logic                        busy,
    output logic                        stop,
    output logic [NUM_CH-1:0]           ovf,
    input  logic [NUM_CH-1:0]           signal,
    output logic [NUM_CH*CNT_WIDTH-1:0] count_ex
);

    localparam int TICK = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK - 1);
    localparam logic [PW-1:0] PRE_RELOAD = (TICK > 1) ? PW'(1) : PW'(0);
    localparam int NB = CNT_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, CLEAR, COUNT, LATCH} state_t;

    state_t                             state;
    logic [7:0]                         off;
    logic                               wr_ctrl;
    logic                               soft_rst;
    logic                               arm;
    logic [15:0]                        gate_reg;
    logic [15:0]                        gate_eff;
    logic [NUM_CH-1:0]                  en_reg;
    logic                               cont_reg;
    logic [NUM_CH-1:0]                  sync1;
    logic [NUM_CH-1:0]                  sync2;
    logic [NUM_CH-1:0]                  sync3;
    logic [NUM_CH-1:0]                  edge_det;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]   live;
    logic [NUM_CH-1:0]                  live_ovf;
    logic [NUM_CH-1:0]                  en_act;
    logic [PW-1:0]                      pre;
    logic [15:0]                        ms;
    logic                               done;
    logic [7:0]                         rd_data;

    assign off      = addr - BASE_ADDR;
    assign wr_ctrl  = we && (off == 8'h00);
    assign soft_rst = wr_ctrl && data_in[0];
    assign arm      = wr_ctrl && data_in[2];
    assign gate_eff = (gate_reg == 16'd0) ? 16'd1 : gate_reg;
    assign edge_det = sync2 & ~sync3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= signal;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // A soft reset also clears CONT; only GATE and ENABLE survive it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_reg <= '0;
            en_reg   <= '0;
            cont_reg <= 1'b0;
        end else if (we) begin
            case (off)
                8'h00:   cont_reg <= data_in[1] & ~data_in[0];
                8'h01:   gate_reg[7:0] <= data_in;
                8'h02:   gate_reg[15:8] <= data_in;
                8'h03:   en_reg <= data_in[NUM_CH-1:0];
                default: ;
            endcase
        end
    end

    // busy doubles as the continue decision: it is loaded from CONT on the final wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            stop     <= 1'b0;
            done     <= 1'b0;
            ovf      <= '0;
            count_ex <= '0;
            live     <= '0;
            live_ovf <= '0;
            en_act   <= '0;
            pre      <= '0;
            ms       <= '0;
        end else if (soft_rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            stop     <= 1'b0;
            done     <= 1'b0;
            ovf      <= '0;
            count_ex <= '0;
            live     <= '0;
            live_ovf <= '0;
            en_act   <= '0;
            pre      <= '0;
            ms       <= '0;
        end else begin
            stop <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || arm) begin
                        done  <= 1'b0;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    live     <= '0;
                    live_ovf <= '0;
                    en_act   <= en_reg;
                    pre      <= '0;
                    ms       <= gate_eff;
                    busy     <= 1'b1;
                    state    <= COUNT;
                end
                COUNT: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (en_act[i] && edge_det[i]) begin
                            if (live[i] == '1)
                                live_ovf[i] <= 1'b1;
                            else
                                live[i] <= live[i] + CNT_WIDTH'(1);
                        end
                    end
                    if (pre == PRE_LAST) begin
                        pre <= '0;
                        ms  <= ms - 16'd1;
                        if (ms == 16'd1) begin
                            busy  <= cont_reg;
                            state <= LATCH;
                        end
                    end else begin
                        pre <= pre + PW'(1);
                    end
                end
                LATCH: begin
                    count_ex <= live;
                    ovf      <= live_ovf;
                    stop     <= 1'b1;
                    done     <= 1'b1;
                    if (busy) begin
                        // This cycle is the first tick of the next window.
                        for (int i = 0; i < NUM_CH; i++)
                            live[i] <= CNT_WIDTH'(en_reg[i] & edge_det[i]);
                        live_ovf <= '0;
                        en_act   <= en_reg;
                        pre      <= PRE_RELOAD;
                        ms       <= gate_eff;
                        state    <= COUNT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (off)
            8'h00: rd_data = {6'b0, cont_reg, 1'b0};
            8'h01: rd_data = gate_reg[7:0];
            8'h02: rd_data = gate_reg[15:8];
            8'h03: rd_data[NUM_CH-1:0] = en_reg;
            8'h04: rd_data = {6'b0, done, busy};
            8'h05: rd_data[NUM_CH-1:0] = ovf;
            default: begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (off == 8'(8 + 4 * ch + b))
                            rd_data = count_ex[ch*CNT_WIDTH + b*8 +: 8];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data_out <= 8'h00;
        else
            data_out <= rd_data;
    end

endmodule

// File: tb/tb_multichannel_gated_counter.sv
// tb/tb_multichannel_gated_counter.sv - self-checking bench for multichannel_gated_counter
module tb_multichannel_gated_counter;

    localparam int         NCH  = 4;
    localparam int         CW   = 8;
    localparam int         FREQ = 10000;
    localparam int         TPM  = FREQ / 1000;
    localparam int         SAT  = (1 << CW) - 1;
    localparam logic [7:0] BASE = 8'h26;

    logic              clk;
    logic              reset;
    logic [7:0]        addr;
    logic [7:0]        data_in;
    logic              we;
    logic [7:0]        data_out;
    logic              start;
    logic              busy;
    logic              stop;
    logic [NCH-1:0]    ovf;
    logic [NCH-1:0]    signal;
    logic [NCH*CW-1:0] count_ex;

    multichannel_gated_counter #(
        .NUM_CH(NCH), .CNT_WIDTH(CW), .CLK_FREQ(FREQ), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we),
        .data_out(data_out), .start(start), .busy(busy), .stop(stop),
        .ovf(ovf), .signal(signal), .count_ex(count_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy_total = 0;
    int stop_total = 0;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_total++;
        if (stop === 1'b1) stop_total++;
    end

    typedef struct packed {
        logic [15:0]       gate;
        logic [3:0]        en;
        logic [3:0][8:0]   npulse;
        logic [3:0][7:0]   exp_cnt;
        logic [3:0]        exp_ovf;
        logic [15:0]       exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] o, input logic [7:0] d);
        @(negedge clk);
        addr = BASE + o; data_in = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] o, output logic [7:0] d);
        @(negedge clk);
        addr = BASE + o;
        @(negedge clk);
        d = data_out;
    endtask

    task automatic program_regs(input logic [15:0] g, input logic [3:0] e, input logic [7:0] c);
        wr(8'h01, g[7:0]);
        wr(8'h02, g[15:8]);
        wr(8'h03, {4'b0, e});
        wr(8'h00, c);
    endtask

    task automatic start_window();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_step(input logic [3:0] m, input int hi, input int lo, input bit st);
        signal = m; start = st;
        @(negedge clk);
        start = 1'b0;
        repeat (hi - 1) @(negedge clk);
        signal = '0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_stop(input int bound, output int waited, output bit seen);
        seen = 1'b0; waited = 0;
        while (!seen && waited < bound) begin
            @(negedge clk);
            waited++;
            if (stop === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic finish_window(input string tag, input int exp_busy, input int b0, input int s0);
        int w; bit seen;
        wait_stop(exp_busy + 50, w, seen);
        check($sformatf("%s stop_seen", tag), 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check($sformatf("%s busy_cycles", tag), 32'(busy_total - b0), 32'(exp_busy));
        check($sformatf("%s stop_pulses", tag), 32'(stop_total - s0), 32'd1);
        check($sformatf("%s busy_after", tag), 32'(busy), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        logic [7:0] d;
        int b0, s0, maxp, w, steps, hot, ex;
        bit seen, st;
        logic [3:0] m, en, eo;
        logic [15:0] g;
        int n[4];

        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int b0, s0, maxp, w, steps, hot, ex;
        bit seen, st;
        logic [3:0] m, en, eo;
        logic [15:0] g;
        int n[4];

        vecs[0] = '{16'd3,     4'hF, {9'd2, 9'd0, 9'd0, 9'd7},   {8'd2, 8'd0, 8'd0, 8'd7},   4'h0, 16'd30};
        vecs[1] = '{16'd3,     4'h5, {9'd5, 9'd5, 9'd5, 9'd5},   {8'd0, 8'd5, 8'd0, 8'd5},   4'h0, 16'd30};
        vecs[2] = '{16'd128,   4'hF, {9'd0, 9'd0, 9'd300, 9'd0}, {8'd0, 8'd0, 8'd255, 8'd0}, 4'h2, 16'd1280};
        vecs[3] = '{16'd0,     4'hF, {9'd0, 9'd0, 9'd0, 9'd0},   {8'd0, 8'd0, 8'd0, 8'd0},   4'h0, 16'd10};
        vecs[4] = '{16'h0101,  4'hA, {9'd4, 9'd3, 9'd2, 9'd1},   {8'd4, 8'd0, 8'd2, 8'd0},   4'h0, 16'd2570};

        reset = 1'b1; addr = '0; data_in = '0; we = 1'b0; start = 1'b0; signal = '0;
        repeat (3) @(negedge clk);
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset stop", 32'(stop), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset count_ex", count_ex, 32'd0);
        reset = 1'b0;
        rd(8'h04, d); check("reset status", 32'(d), 32'd0);
        rd(8'h03, d); check("reset enable", 32'(d), 32'd0);

        for (int v = 0; v < 5; v++) begin
            program_regs(vecs[v].gate, vecs[v].en, 8'h00);
            b0 = busy_total; s0 = stop_total;
            start_window();
            maxp = 0;
            for (int ch = 0; ch < 4; ch++)
                if (int'(vecs[v].npulse[ch]) > maxp) maxp = int'(vecs[v].npulse[ch]);
            for (int s = 0; s < maxp; s++) begin
                m = '0;
                for (int ch = 0; ch < 4; ch++) m[ch] = (s < int'(vecs[v].npulse[ch]));
                pulse_step(m, 2, 2, 1'b0);
            end
            finish_window($sformatf("vec%0d", v), int'(vecs[v].exp_busy), b0, s0);
            for (int ch = 0; ch < 4; ch++)
                check($sformatf("vec%0d count ch%0d", v, ch), 32'(count_ex[ch*CW +: CW]), 32'(vecs[v].exp_cnt[ch]));
            check($sformatf("vec%0d ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
            rd(8'h04, d); check($sformatf("vec%0d status", v), 32'(d), 32'h02);
            rd(8'h05, d); check($sformatf("vec%0d ovf reg", v), 32'(d), 32'(vecs[v].exp_ovf));
            if (v == 0) begin
                rd(8'h7F, d); check("unmapped read", 32'(d), 32'd0);
                @(negedge clk); addr = BASE + 8'h08;
                #1 check("read latency old", 32'(data_out), 32'd0);
                @(negedge clk); check("snap ch0 b0", 32'(data_out), 32'h07);
                rd(8'h09, d); check("snap ch0 b1", 32'(d), 32'd0);
                rd(8'h0A, d); check("snap ch0 b2", 32'(d), 32'd0);
                rd(8'h0B, d); check("snap ch0 b3", 32'(d), 32'd0);
                rd(8'h0C, d); check("snap ch1 b0", 32'(d), 32'd0);
                rd(8'h14, d); check("snap ch3 b0", 32'(d), 32'h02);
            end
        end

        // Soft reset mid-window, with a non-zero snapshot still held from the last vector.
        program_regs(16'h0205, 4'h9, 8'h00);
        start_window();
        repeat (15) @(negedge clk);
        check("srst busy before", 32'(busy), 32'd1);
        s0 = stop_total;
        wr(8'h00, 8'h01);
        check("srst busy dropped", 32'(busy), 32'd0);
        check("srst count_ex", count_ex, 32'd0);
        check("srst ovf", 32'(ovf), 32'd0);
        repeat (30) @(negedge clk);
        check("srst no stop", 32'(stop_total - s0), 32'd0);
        rd(8'h01, d); check("srst gate_lo", 32'(d), 32'h05);
        rd(8'h02, d); check("srst gate_hi", 32'(d), 32'h02);
        rd(8'h03, d); check("srst enable", 32'(d), 32'h09);
        rd(8'h04, d); check("srst status", 32'(d), 32'd0);

        // Continuous mode: a pulse landing in the LATCH cycle belongs to the next window.
        program_regs(16'd1, 4'hF, 8'h02);
        wr(8'h00, 8'h06);
        wait_stop(40, w, seen);
        check("cont first stop", 32'(seen), 32'd1);
        check("cont busy held", 32'(busy), 32'd1);
        repeat (7) @(negedge clk);
        signal = 4'b0001;
        repeat (2) @(negedge clk);
        signal = '0;
        wait_stop(20, w, seen);
        check("cont gap1", 32'(w + 9), 32'd10);
        check("cont snap excludes", 32'(count_ex[7:0]), 32'd0);
        wait_stop(20, w, seen);
        check("cont gap2", 32'(w), 32'd10);
        check("cont snap includes", count_ex, 32'h0000_0001);
        wr(8'h00, 8'h00);
        wait_stop(20, w, seen);
        check("cont final stop", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("cont idle busy", 32'(busy), 32'd0);
        s0 = stop_total;
        repeat (30) @(negedge clk);
        check("cont idle no stop", 32'(stop_total - s0), 32'd0);

        // Randomised windows against the counting rules: enabled channels count min(n, 2^W-1).
        for (int t = 0; t < 6; t++) begin
            en = 4'($urandom_range(0, 15));
            hot = $urandom_range(0, 3);
            steps = $urandom_range(1, 300);
            g = 16'(steps * 6 / 10 + 3);
            for (int ch = 0; ch < 4; ch++) n[ch] = 0;
            program_regs(g, en, 8'h00);
            b0 = busy_total; s0 = stop_total;
            start_window();
            for (int s = 0; s < steps; s++) begin
                m = 4'($urandom) | 4'(1 << hot);
                st = (s == steps / 2);
                pulse_step(m, $urandom_range(2, 3), $urandom_range(2, 3), st);
                for (int ch = 0; ch < 4; ch++) if (m[ch]) n[ch]++;
            end
            finish_window($sformatf("rnd%0d", t), int'(g) * TPM, b0, s0);
            eo = '0;
            for (int ch = 0; ch < 4; ch++) begin
                ex = en[ch] ? ((n[ch] > SAT) ? SAT : n[ch]) : 0;
                eo[ch] = en[ch] && (n[ch] > SAT);
                check($sformatf("rnd%0d count ch%0d", t, ch), 32'(count_ex[ch*CW +: CW]), 32'(ex));
            end
            check($sformatf("rnd%0d ovf", t), 32'(ovf), 32'(eo));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
